// File: rtl/psum_acc_spad_pkg.sv
// Shared psum types: scratchpad FSM states and the saturation helper used by the
// scratchpad adder and the MAC.
package psum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DRAIN
    } spad_state_e;

    typedef enum logic [1:0] {
        SAT_NONE,
        SAT_POS,
        SAT_NEG
    } sat_kind_e;

    // A W+1-bit signed sum of two W-bit operands overflowed W bits exactly when
    // its top two bits disagree; the top bit tells the direction.
    function automatic sat_kind_e sat_kind(input logic sign_ext, input logic sign_w);
        if (sign_ext == sign_w) begin
            return SAT_NONE;
        end else if (!sign_ext) begin
            return SAT_POS;
        end else begin
            return SAT_NEG;
        end
    endfunction

endpackage

// File: rtl/psum_acc_spad_if.sv
// Accumulate request and drain stream handshakes of the psum scratchpad.
interface psum_acc_spad_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
);
    logic                         acc_valid;
    logic                         acc_ready;
    logic [ADDR_WIDTH-1:0]        acc_addr;
    logic signed [DATA_WIDTH-1:0] acc_din;
    logic                         acc_load;

    logic                         drain_valid;
    logic                         drain_ready;
    logic signed [DATA_WIDTH-1:0] drain_data;
    logic                         drain_last;

    modport master (
        output acc_valid, acc_addr, acc_din, acc_load, drain_ready,
        input  acc_ready, drain_valid, drain_data, drain_last
    );

    modport slave (
        input  acc_valid, acc_addr, acc_din, acc_load, drain_ready,
        output acc_ready, drain_valid, drain_data, drain_last
    );
endinterface

// File: rtl/psum_sat_add.sv
// Signed W-bit adder; SATURATE!=0 clamps to the signed range, otherwise wraps.
module psum_sat_add
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SATURATE   = 1
) (
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] sum_o
);

    logic signed [DATA_WIDTH:0] sum_ext;

    always_comb begin
        sum_ext = {a_i[DATA_WIDTH-1], a_i} + {b_i[DATA_WIDTH-1], b_i};
        sum_o   = sum_ext[DATA_WIDTH-1:0];
        if (SATURATE != 0) begin
            case (sat_kind(sum_ext[DATA_WIDTH], sum_ext[DATA_WIDTH-1]))
                SAT_POS: sum_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
                SAT_NEG: sum_o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/psum_acc_spad.sv
// Partial-sum scratchpad: in-place accumulate (2-stage RMW), bulk clear,
// valid/ready drain stream and an always-on registered read port.
module psum_acc_spad
    import psum_pkg::*;
#(
    parameter int MEM_DEPTH      = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = $clog2(MEM_DEPTH),
    parameter int SATURATE       = 1,
    parameter int CLEAR_ON_DRAIN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    psum_acc_spad_if.slave        bus,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  clr_start,
    input  logic                  drain_start,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    logic signed [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    spad_state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]        idx_q, idx_d;
    logic                         fetch_done_q, fetch_done_d;

    logic                         s1_valid_q;
    logic [ADDR_WIDTH-1:0]        s1_addr_q;
    logic signed [DATA_WIDTH-1:0] s1_din_q;
    logic                         s1_load_q;

    logic                         drain_valid_q, drain_valid_d;
    logic signed [DATA_WIDTH-1:0] drain_data_q, drain_data_d;
    logic                         drain_last_q, drain_last_d;
    logic [DATA_WIDTH-1:0]        rd_data_q;

    logic                         fetch;
    logic signed [DATA_WIDTH-1:0] s2_old, s2_sum;
    logic                         we;
    logic [ADDR_WIDTH-1:0]        waddr;
    logic signed [DATA_WIDTH-1:0] wdata;

    assign bus.acc_ready   = (state_q == IDLE) && !clr_start && !drain_start;
    assign bus.drain_valid = drain_valid_q;
    assign bus.drain_data  = drain_data_q;
    assign bus.drain_last  = drain_last_q;
    assign busy            = (state_q != IDLE);
    assign rd_data         = rd_data_q;

    assign s2_old = mem[s1_addr_q];

    psum_sat_add #(
        .DATA_WIDTH(DATA_WIDTH),
        .SATURATE  (SATURATE)
    ) u_sat_add (
        .a_i  (s2_old),
        .b_i  (s1_din_q),
        .sum_o(s2_sum)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        fetch_done_d  = fetch_done_q;
        drain_valid_d = drain_valid_q;
        drain_data_d  = drain_data_q;
        drain_last_d  = drain_last_q;
        fetch         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                end else if (drain_start) begin
                    state_d = DRAIN;
                end
            end
            CLEAR: begin
                idx_d = idx_q + ONE;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            DRAIN: begin
                if (!drain_valid_q || bus.drain_ready) begin
                    if (drain_valid_q && drain_last_q) begin
                        state_d       = IDLE;
                        drain_valid_d = 1'b0;
                        drain_last_d  = 1'b0;
                        fetch_done_d  = 1'b0;
                        idx_d         = '0;
                    end else if (!fetch_done_q) begin
                        fetch         = 1'b1;
                        drain_valid_d = 1'b1;
                        drain_data_d  = mem[idx_q];
                        drain_last_d  = (idx_q == LAST_IDX);
                        idx_d         = idx_q + ONE;
                        if (idx_q == LAST_IDX) begin
                            fetch_done_d = 1'b1;
                            idx_d        = '0;
                        end
                    end else begin
                        drain_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage-2 writes only follow IDLE-cycle accepts, so they never collide with
    // clear/drain-fetch writes, which happen strictly after the FSM transition.
    always_comb begin
        we    = 1'b0;
        waddr = s1_addr_q;
        wdata = s1_load_q ? s1_din_q : s2_sum;
        if (s1_valid_q) begin
            we = 1'b1;
        end else if (state_q == CLEAR || (fetch && CLEAR_ON_DRAIN != 0)) begin
            we    = 1'b1;
            waddr = idx_q;
            wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            fetch_done_q  <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_addr_q     <= '0;
            s1_din_q      <= '0;
            s1_load_q     <= 1'b0;
            drain_valid_q <= 1'b0;
            drain_data_q  <= '0;
            drain_last_q  <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            fetch_done_q  <= fetch_done_d;
            drain_valid_q <= drain_valid_d;
            drain_data_q  <= drain_data_d;
            drain_last_q  <= drain_last_d;
            rd_data_q     <= mem[rd_addr];
            s1_valid_q    <= bus.acc_valid && bus.acc_ready;
            if (bus.acc_valid && bus.acc_ready) begin
                s1_addr_q <= bus.acc_addr;
                s1_din_q  <= bus.acc_din;
                s1_load_q <= bus.acc_load;
            end
        end
    end

endmodule

// File: tb/tb_psum_acc_spad.sv
// Scoreboard bench for psum_acc_spad: stimulus queues expected read/drain values,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_psum_acc_spad;

    localparam int DEPTH = 24;
    localparam int W     = 16;
    localparam int AW    = 5;

    typedef struct {
        int data;
        bit last;
    } drain_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psum_acc_spad_if #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) bus ();
    psum_acc_spad_if #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) bus_b ();

    logic [AW-1:0] rd_addr, rd_addr_b;
    logic [W-1:0]  rd_data, rd_data_b;
    logic          clr_start, drain_start, busy;
    logic          clr_start_b, drain_start_b, busy_b;

    psum_acc_spad #(
        .MEM_DEPTH(DEPTH), .DATA_WIDTH(W), .ADDR_WIDTH(AW), .SATURATE(1), .CLEAR_ON_DRAIN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .rd_addr(rd_addr), .rd_data(rd_data),
        .clr_start(clr_start), .drain_start(drain_start), .busy(busy)
    );

    psum_acc_spad #(
        .MEM_DEPTH(DEPTH), .DATA_WIDTH(W), .ADDR_WIDTH(AW), .SATURATE(0), .CLEAR_ON_DRAIN(1)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .clr_start(clr_start_b), .drain_start(drain_start_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;
    int rd_q[$];
    drain_t drain_q[$];
    logic rd_req = 1'b0;
    logic rd_pend = 1'b0;
    int hs_cnt = 0;
    int mon_e;
    drain_t mon_d;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                mon_e = rd_q.pop_front();
                check("rd_data", int'($signed(rd_data)), mon_e);
            end
        end
        if (bus.drain_valid) begin
            if (drain_q.size() == 0) begin
                check("drain_unexpected", 1, 0);
            end else if (bus.drain_ready) begin
                mon_d = drain_q.pop_front();
                check("drain_data", int'(bus.drain_data), mon_d.data);
                check("drain_last", int'(bus.drain_last), int'(mon_d.last));
                hs_cnt++;
            end else begin
                check("drain_hold", int'(bus.drain_data), drain_q[0].data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input int addr, input int exp);
        rd_addr = AW'(addr);
        rd_req  = 1'b1;
        rd_q.push_back(exp);
        tick();
        rd_req  = 1'b0;
    endtask

    task automatic acc_issue(input int addr, input int din, input bit load);
        bus.acc_valid = 1'b1;
        bus.acc_addr  = AW'(addr);
        bus.acc_din   = W'(din);
        bus.acc_load  = load;
        tick();
    endtask

    task automatic acc_b(input int addr, input int din, input bit load);
        bus_b.acc_valid = 1'b1;
        bus_b.acc_addr  = AW'(addr);
        bus_b.acc_din   = W'(din);
        bus_b.acc_load  = load;
        tick();
        bus_b.acc_valid = 1'b0;
    endtask

    task automatic push_drain(input int base, input int step);
        for (int i = 0; i < DEPTH; i++) begin
            drain_q.push_back('{data: base + i * step, last: (i == DEPTH - 1)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        bit saw_dv;
        bus.acc_valid = 1'b0; bus.acc_addr = '0; bus.acc_din = '0; bus.acc_load = 1'b0;
        bus.drain_ready = 1'b0;
        bus_b.acc_valid = 1'b0; bus_b.acc_addr = '0; bus_b.acc_din = '0; bus_b.acc_load = 1'b0;
        bus_b.drain_ready = 1'b0;
        rd_addr = '0; rd_addr_b = '0;
        clr_start = 1'b0; drain_start = 1'b0;
        clr_start_b = 1'b0; drain_start_b = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_drain_valid", int'(bus.drain_valid), 0);
        check("rst_drain_last", int'(bus.drain_last), 0);
        check("rst_drain_data", int'(bus.drain_data), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_acc_ready", int'(bus.acc_ready), 1);
        rst_n = 1'b1;
        tick();

        // CLEAR: busy for exactly DEPTH cycles, then everything reads 0
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        check("clear_busy_cycles", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) rd_check(i, 0);

        // Back-to-back accumulate to one address
        acc_issue(5, 100, 1'b1);
        acc_issue(5, 20, 1'b0);
        acc_issue(5, -7, 1'b0);
        acc_issue(5, 3, 1'b0);
        bus.acc_valid = 1'b0;
        tick();
        rd_check(5, 116);

        // Saturation (SATURATE=1)
        acc_issue(7, 32760, 1'b1);
        acc_issue(7, 100, 1'b0);
        acc_issue(8, -32768, 1'b1);
        acc_issue(8, -1, 1'b0);
        bus.acc_valid = 1'b0;
        tick();
        rd_check(7, 32767);
        rd_check(8, -32768);

        // Wrap (SATURATE=0)
        acc_b(7, 32760, 1'b1);
        acc_b(7, 100, 1'b0);
        acc_b(8, -32768, 1'b1);
        acc_b(8, -1, 1'b0);
        tick();
        rd_addr_b = AW'(7);
        tick();
        check("wrap_pos", int'($signed(rd_data_b)), -32676);
        rd_addr_b = AW'(8);
        tick();
        check("wrap_neg", int'($signed(rd_data_b)), 32767);

        // Drain with alternating backpressure
        for (int i = 0; i < DEPTH; i++) acc_issue(i, i * 3, 1'b1);
        bus.acc_valid = 1'b0;
        tick();
        push_drain(0, 3);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        check("drain_first_not_yet", int'(bus.drain_valid), 0);
        bus.drain_ready = 1'b1;
        tick();
        check("drain_first_valid", int'(bus.drain_valid), 1);
        k = 0;
        while (busy && k < 200) begin
            bus.drain_ready = (k % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            k++;
        end
        bus.drain_ready = 1'b0;
        check("drain_done_idle", int'(busy), 0);
        check("drain_valid_after", int'(bus.drain_valid), 0);
        check("drain_all_seen", drain_q.size(), 0);
        for (int i = 0; i < DEPTH; i++) rd_check(i, 0);

        // Simultaneous clr_start and drain_start: CLEAR only
        acc_issue(2, 55, 1'b1);
        bus.acc_valid = 1'b0;
        tick();
        clr_start = 1'b1;
        drain_start = 1'b1;
        #1;
        check("start_acc_ready_low", int'(bus.acc_ready), 0);
        tick();
        clr_start = 1'b0;
        drain_start = 1'b0;
        n = 0;
        saw_dv = 1'b0;
        while (busy && n < 100) begin
            if (bus.drain_valid) saw_dv = 1'b1;
            n++;
            tick();
        end
        check("clr_wins_busy", n, DEPTH);
        check("clr_wins_no_drain", int'(saw_dv), 0);
        rd_check(2, 0);

        // Accumulate accepted just before start lands; one offered with start is dropped
        acc_issue(4, 9, 1'b1);
        acc_issue(6, 66, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            drain_q.push_back('{data: (i == 4) ? 9 : ((i == 6) ? 66 : 0), last: (i == DEPTH - 1)});
        end
        bus.acc_addr = AW'(4);
        bus.acc_din  = W'(1000);
        bus.acc_load = 1'b1;
        drain_start  = 1'b1;
        bus.drain_ready = 1'b1;
        #1;
        check("drain_start_acc_ready", int'(bus.acc_ready), 0);
        tick();
        drain_start = 1'b0;
        bus.acc_valid = 1'b0;
        n = 0;
        k = 0;
        while (busy && k < 100) begin
            if (bus.drain_valid) n++;
            k++;
            tick();
        end
        check("drain_valid_cycles", n, DEPTH);
        check("drain2_all_seen", drain_q.size(), 0);
        bus.drain_ready = 1'b0;
        rd_check(4, 0);
        rd_check(6, 0);

        // Reset in the middle of a drain, then a fresh drain from entry 0
        for (int i = 0; i < DEPTH; i++) acc_issue(i, i + 1, 1'b1);
        bus.acc_valid = 1'b0;
        tick();
        push_drain(1, 1);
        hs_cnt = 0;
        bus.drain_ready = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        k = 0;
        while (hs_cnt < 10 && k < 100) begin k++; tick(); end
        check("mid_drain_count", hs_cnt, 10);
        check("mid_drain_entry", int'(bus.drain_data), 11);
        rst_n = 1'b0;
        bus.drain_ready = 1'b0;
        #1;
        drain_q.delete();
        check("mid_rst_drain_valid", int'(bus.drain_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_acc_ready", int'(bus.acc_ready), 1);
        check("post_rst_drain_valid", int'(bus.drain_valid), 0);
        for (int i = 0; i < DEPTH; i++) acc_issue(i, 200 + i, 1'b1);
        bus.acc_valid = 1'b0;
        tick();
        push_drain(200, 1);
        hs_cnt = 0;
        bus.drain_ready = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        k = 0;
        while (busy && k < 100) begin k++; tick(); end
        bus.drain_ready = 1'b0;
        check("restart_handshakes", hs_cnt, DEPTH);
        check("restart_all_seen", drain_q.size(), 0);
        tick();
        check("rd_all_seen", rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
